// File: rtl/csb_outstanding_tracker_if.sv
// ============================================================================
// Module   : csb_outstanding_tracker_if
// Function : Upstream/downstream CSB request and response bundle for the tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csb_outstanding_tracker_if;
  // upstream (bridge side)
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_addr;
  logic [31:0] s_wdat;
  logic        s_write;
  logic        s_nposted;
  logic        s_r_valid;
  logic [31:0] s_r_data;
  logic        s_wr_complete;
  // downstream (NVDLA side)
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_addr;
  logic [31:0] m_wdat;
  logic        m_write;
  logic        m_nposted;
  logic        m_r_valid;
  logic [31:0] m_r_data;
  logic        m_wr_complete;

  modport master (
    input  s_valid, s_addr, s_wdat, s_write, s_nposted,
    input  m_ready, m_r_valid, m_r_data, m_wr_complete,
    output s_ready, s_r_valid, s_r_data, s_wr_complete,
    output m_valid, m_addr, m_wdat, m_write, m_nposted
  );

  modport slave (
    output s_valid, s_addr, s_wdat, s_write, s_nposted,
    output m_ready, m_r_valid, m_r_data, m_wr_complete,
    input  s_ready, s_r_valid, s_r_data, s_wr_complete,
    input  m_valid, m_addr, m_wdat, m_write, m_nposted
  );
endinterface

`default_nettype wire

// File: rtl/csb_outstanding_tracker.sv
// ============================================================================
// Module   : csb_outstanding_tracker
// Function : One-entry CSB request stage with credit limit and response type
//            checking; optional response timeout under `CSB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csb_outstanding_tracker #(
  parameter int MAX_OUTST      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire                        clk,
  input  wire                        rst_n,
  csb_outstanding_tracker_if.master  bus,
  output logic [3:0]                 outstanding_o,
  output logic                       err_o
);

  localparam int                PTR_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [3:0]        MAX_CNT  = 4'(MAX_OUTST);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(MAX_OUTST - 1);
  localparam logic [31:0]       TMO_DATA = 32'hDEAD_BEEF;

  if (MAX_OUTST < 1 || MAX_OUTST > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("csb_outstanding_tracker: parameter out of range");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                 rdy_q;
  logic                 m_valid_q,   m_valid_d;
  logic [15:0]          m_addr_q,    m_addr_d;
  logic [31:0]          m_wdat_q,    m_wdat_d;
  logic                 m_write_q,   m_write_d;
  logic                 m_nposted_q, m_nposted_d;
  logic [3:0]           cnt_q,       cnt_d;
  logic [MAX_OUTST-1:0] fifo_q,      fifo_d;
  logic [PTR_W-1:0]     wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,    rd_ptr_d;
  logic                 s_r_valid_q, s_r_valid_d;
  logic [31:0]          s_r_data_q,  s_r_data_d;
  logic                 s_wrc_q,     s_wrc_d;
  logic                 err_q,       err_d;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  logic w_s_ready;
  logic w_s_hs;
  logic w_push;

  // rdy_q keeps s_ready low while reset is asserted and for the first edge after
  assign w_s_ready = rdy_q && (!m_valid_q || bus.m_ready) && (cnt_q < MAX_CNT);
  assign w_s_hs    = bus.s_valid && w_s_ready;
  assign w_push    = w_s_hs && (!bus.s_write || bus.s_nposted);

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------
  logic w_nonempty;
  logic w_head_wr;
  logic w_rd_match;
  logic w_wr_match;
  logic w_match;
  logic w_bad;
  logic w_to;
  logic w_pop;

  // credit count equals type-FIFO occupancy: both step on the same events
  assign w_nonempty = (cnt_q != 4'd0);
  assign w_head_wr  = fifo_q[rd_ptr_q];
  assign w_rd_match = bus.m_r_valid && !bus.m_wr_complete && w_nonempty && !w_head_wr;
  assign w_wr_match = bus.m_wr_complete && !bus.m_r_valid && w_nonempty && w_head_wr;
  assign w_match    = w_rd_match || w_wr_match;
  assign w_bad      = (bus.m_r_valid || bus.m_wr_complete) && !w_match;
  assign w_pop      = w_match || w_to;

`ifdef CSB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] timer_q, timer_d;

  assign w_to = w_nonempty && !w_match && (timer_q == TMR_W'(TIMEOUT_CYCLES));

  always_comb begin
    timer_d = timer_q + 1'b1;
    if (w_pop || !w_nonempty) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign w_to = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    m_valid_d   = m_valid_q;
    m_addr_d    = m_addr_q;
    m_wdat_d    = m_wdat_q;
    m_write_d   = m_write_q;
    m_nposted_d = m_nposted_q;
    cnt_d       = cnt_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    s_r_valid_d = w_rd_match || (w_to && !w_head_wr);
    s_r_data_d  = s_r_data_q;
    s_wrc_d     = w_wr_match || (w_to && w_head_wr);
    err_d       = err_q || w_bad || w_to;

    if (w_s_hs) begin
      m_valid_d   = 1'b1;
      m_addr_d    = bus.s_addr;
      m_wdat_d    = bus.s_wdat;
      m_write_d   = bus.s_write;
      m_nposted_d = bus.s_nposted;
    end else if (bus.m_ready) begin
      m_valid_d   = 1'b0;
    end

    if (w_push) begin
      fifo_d[wr_ptr_q] = bus.s_write;
      wr_ptr_d         = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase

    if (w_rd_match) begin
      s_r_data_d = bus.m_r_data;
    end else if (w_to && !w_head_wr) begin
      s_r_data_d = TMO_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdat_q    <= '0;
      m_write_q   <= 1'b0;
      m_nposted_q <= 1'b0;
      cnt_q       <= '0;
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      s_r_valid_q <= 1'b0;
      s_r_data_q  <= '0;
      s_wrc_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rdy_q       <= 1'b1;
      m_valid_q   <= m_valid_d;
      m_addr_q    <= m_addr_d;
      m_wdat_q    <= m_wdat_d;
      m_write_q   <= m_write_d;
      m_nposted_q <= m_nposted_d;
      cnt_q       <= cnt_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      s_r_valid_q <= s_r_valid_d;
      s_r_data_q  <= s_r_data_d;
      s_wrc_q     <= s_wrc_d;
      err_q       <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.s_ready       = w_s_ready;
  assign bus.s_r_valid     = s_r_valid_q;
  assign bus.s_r_data      = s_r_data_q;
  assign bus.s_wr_complete = s_wrc_q;
  assign bus.m_valid       = m_valid_q;
  assign bus.m_addr        = m_addr_q;
  assign bus.m_wdat        = m_wdat_q;
  assign bus.m_write       = m_write_q;
  assign bus.m_nposted     = m_nposted_q;
  assign outstanding_o     = cnt_q;
  assign err_o             = err_q;

endmodule

`default_nettype wire

// File: tb/tb_csb_outstanding_tracker.sv
// ============================================================================
// Module   : tb_csb_outstanding_tracker
// Function : Directed scoreboard bench for csb_outstanding_tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csb_outstanding_tracker;

  localparam int MAX_OUTST      = 4;
  localparam int TIMEOUT_CYCLES = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] outstanding;
  logic       err;

  csb_outstanding_tracker_if bus ();

  csb_outstanding_tracker #(
    .MAX_OUTST      (MAX_OUTST),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] wdat;
    logic        wr;
    logic        np;
  } req_t;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    int          cyc;   // -1: arrival cycle not checked
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t r;
  rsp_t e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Monitor: request transfers in order, upstream responses against expectations
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_valid && bus.m_ready) begin
        if (req_q.size() == 0) begin
          check("unexp_req", 1, 0);
        end else begin
          r = req_q.pop_front();
          check("req_addr",  bus.m_addr,    r.addr);
          check("req_wdat",  bus.m_wdat,    r.wdat);
          check("req_write", bus.m_write,   r.wr);
          check("req_np",    bus.m_nposted, r.np);
        end
      end
      if (bus.s_valid && bus.s_ready)
        req_q.push_back('{bus.s_addr, bus.s_wdat, bus.s_write, bus.s_nposted});
      if (bus.s_r_valid || bus.s_wr_complete) begin
        if (rsp_q.size() == 0) begin
          check("unexp_rsp", {bus.s_r_valid, bus.s_wr_complete}, 0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_kind", {bus.s_r_valid, bus.s_wr_complete}, e.wr ? 2'b01 : 2'b10);
          if (!e.wr) check("rsp_data", bus.s_r_data, e.data);
          if (e.cyc >= 0) check("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Returns one cycle after the handshake edge
  task automatic send(input logic [15:0] addr, input logic [31:0] wdat,
                      input logic wr, input logic np);
    bit ok;
    ok            = 1'b0;
    bus.s_valid   = 1'b1;
    bus.s_addr    = addr;
    bus.s_wdat    = wdat;
    bus.s_write   = wr;
    bus.s_nposted = np;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic rsp(input logic wr, input logic [31:0] data, input logic fwd);
    bus.m_r_valid     = !wr;
    bus.m_wr_complete = wr;
    bus.m_r_data      = data;
    if (fwd) rsp_q.push_back('{wr, data, cyc + 1});
    tick();
    bus.m_r_valid     = 1'b0;
    bus.m_wr_complete = 1'b0;
  endtask

  initial begin
    int acc;
    bus.s_valid = 0; bus.s_addr = 0; bus.s_wdat = 0; bus.s_write = 0; bus.s_nposted = 0;
    bus.m_ready = 1; bus.m_r_valid = 0; bus.m_r_data = 0; bus.m_wr_complete = 0;

    // reset state
    repeat (2) tick();
    check("rst_s_ready",   bus.s_ready,       0);
    check("rst_m_valid",   bus.m_valid,       0);
    check("rst_s_r_valid", bus.s_r_valid,     0);
    check("rst_s_r_data",  bus.s_r_data,      0);
    check("rst_wr_cmpl",   bus.s_wr_complete, 0);
    check("rst_cnt",       outstanding,       0);
    check("rst_err",       err,               0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", bus.s_ready, 1);

    // single read with delayed response
    send(16'h0010, 32'h0, 1'b0, 1'b0);
    check("rd_m_valid", bus.m_valid, 1);
    check("rd_m_addr",  bus.m_addr,  16'h0010);
    check("rd_cnt1",    outstanding, 1);
    tick();
    tick();
    rsp(1'b0, 32'h1234_5678, 1'b1);
    check("rd_s_r_valid", bus.s_r_valid, 1);
    check("rd_s_r_data",  bus.s_r_data,  32'h1234_5678);
    check("rd_cnt0",      outstanding,   0);
    tick();
    check("rd_pulse_end", bus.s_r_valid, 0);

    // credit limit: five back-to-back reads
    bus.s_valid = 1'b1; bus.s_write = 1'b0; bus.s_nposted = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.s_addr = 16'h0200 + 16'(acc);
      @(negedge clk);
      if (bus.s_ready) acc++;
      tick();
    end
    check("full_accepts", acc,         4);
    check("full_ready0",  bus.s_ready, 0);
    check("full_cnt4",    outstanding, 4);
    rsp(1'b0, 32'hB0B0_0001, 1'b1);
    check("full_ready1",  bus.s_ready, 1);
    tick();
    bus.s_valid = 1'b0;
    check("full_refill",  outstanding, 4);
    for (int i = 0; i < 4; i++) rsp(1'b0, 32'hB0B0_0010 + 32'(i), 1'b1);
    check("full_drained", outstanding, 0);

    // posted write: forwarded, no credit
    send(16'h0100, 32'hCAFE_F00D, 1'b1, 1'b0);
    check("pw_cnt", outstanding, 0);
    repeat (3) tick();
    check("pw_cnt_later", outstanding, 0);

    // non-posted write answered first with the wrong type
    check("np_err0", err, 0);
    send(16'h0300, 32'h5555_AAAA, 1'b1, 1'b1);
    check("np_cnt1", outstanding, 1);
    tick();
    rsp(1'b0, 32'hDEAD_0000, 1'b0);
    check("np_err1",      err,           1);
    check("np_cnt_kept",  outstanding,   1);
    check("np_no_rvalid", bus.s_r_valid, 0);
    rsp(1'b1, 32'h0, 1'b1);
    check("np_wr_cmpl",   bus.s_wr_complete, 1);
    check("np_cnt0",      outstanding,       0);
    check("rdata_hold",   bus.s_r_data,      32'hB0B0_0013);

    // downstream stall, then reset mid-hold
    bus.m_ready = 1'b0;
    send(16'h0400, 32'h0000_0001, 1'b0, 1'b0);
    bus.s_valid = 1'b1; bus.s_addr = 16'h0500; bus.s_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ready0",  bus.s_ready, 0);
      check("hold_m_valid", bus.m_valid, 1);
      check("hold_m_addr",  bus.m_addr,  16'h0400);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_s_ready", bus.s_ready, 0);
    check("arst_m_valid", bus.m_valid, 0);
    check("arst_m_addr",  bus.m_addr,  0);
    check("arst_cnt",     outstanding, 0);
    check("arst_err",     err,         0);
    req_q.delete();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    repeat (3) tick();
    check("post_rst_cnt", outstanding, 0);

    // response with nothing outstanding
    rsp(1'b1, 32'h0, 1'b0);
    check("empty_err",     err,               1);
    check("empty_no_cmpl", bus.s_wr_complete, 0);

    // read and write-complete asserted together
    do_reset();
    send(16'h0600, 32'h0, 1'b0, 1'b0);
    tick();
    bus.m_r_valid = 1'b1; bus.m_wr_complete = 1'b1; bus.m_r_data = 32'h0BAD_0BAD;
    tick();
    bus.m_r_valid = 1'b0; bus.m_wr_complete = 1'b0;
    check("both_err",    err,               1);
    check("both_cnt",    outstanding,       1);
    check("both_no_rd",  bus.s_r_valid,     0);
    check("both_no_wr",  bus.s_wr_complete, 0);
    rsp(1'b0, 32'h600D_600D, 1'b1);
    check("both_cnt0",   outstanding,       0);

`ifdef CSB_TIMEOUT_EN
    // unanswered read is completed by the timeout
    do_reset();
    send(16'h0700, 32'h0, 1'b0, 1'b0);
    rsp_q.push_back('{1'b0, 32'hDEAD_BEEF, -1});
    for (int i = 0; i < 40 && rsp_q.size() != 0; i++) tick();
    check("to_fired", rsp_q.size(), 0);
    tick();
    check("to_err",   err,          1);
    check("to_cnt0",  outstanding,  0);
    rsp(1'b0, 32'h0000_0001, 1'b0);
`endif

    repeat (3) tick();
    check("req_q_empty", req_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/csb_outstanding_tracker.md
# csb_outstanding_tracker

Request buffer and response tracker between the peripheral-to-CSB bridge (upstream) and the NVDLA CSB port (downstream). It registers each CSB request for one stage and limits in-flight requests that need a response (reads and non-posted writes) to `MAX_OUTST`. It checks the returning read-data and write-complete responses against a type FIFO, registers them back upstream, and drops and flags protocol violations.

## Interface
- `MAX_OUTST`, default 4: maximum in-flight response-bearing requests, range 1..15.
- `TIMEOUT_CYCLES`, default 1024: response timeout, used only with the timeout feature; minimum 2.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `s_valid`  in  1  upstream request valid.
- `s_ready`  out  1  upstream request ready.
- `s_addr`  in  16  request address.
- `s_wdat`  in  32  write data.
- `s_write`  in  1  1 = write, 0 = read.
- `s_nposted`  in  1  write needs a write-complete response.
- `s_r_valid`  out  1  read data valid to upstream.
- `s_r_data`  out  32  read data to upstream.
- `s_wr_complete`  out  1  write-complete pulse to upstream.
- `m_valid`, `m_addr`[16], `m_wdat`[32], `m_write`, `m_nposted`  out  request to NVDLA.
- `m_ready`  in  1  NVDLA request ready.
- `m_r_valid`  in  1 and `m_r_data`  in  32  read response from NVDLA.
- `m_wr_complete`  in  1  write-complete from NVDLA.
- `outstanding_o`  out  4  current credit count.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
- A request "needs response" (NR) when `!s_write || s_nposted`.
- Request stage is one entry, `m_*` registered.
  - `s_ready = (!m_valid || m_ready) && (cnt < MAX_OUTST)`.
  - The credit gate applies to all requests, including posted writes.
  - Upstream handshake loads the stage.
  - `m_*` stays stable while `m_valid && !m_ready`.
- Credit counter `cnt`:
  - +1 on an upstream handshake of an NR request.
  - −1 on a pop.
  - Simultaneous +1 and −1 leaves `cnt` unchanged.
- Type FIFO, depth `MAX_OUTST`, 1 bit per entry (0 = read, 1 = write): pushed on the NR upstream handshake, popped on a matched response.
- A response is matched when the FIFO is non-empty and either:
  - `m_r_valid` with head = read, or
  - `m_wr_complete` with head = write.
- A matched response is forwarded and popped.
- Any of the following drops the response (not forwarded) and sets `err_o`:
  - response while the FIFO is empty,
  - type mismatch with the head,
  - `m_r_valid && m_wr_complete` in the same cycle.
- `err_o` clears only on reset.

## Timing
- All outputs reset to 0; `cnt`, FIFO pointers and the timer reset to 0.
- Request latency: upstream handshake in cycle N gives `m_valid` = 1 in cycle N+1.
- Back-to-back throughput is 1 per cycle while `m_ready` = 1 and credits remain.
- Response latency: matched `m_r_valid`/`m_wr_complete` in cycle N gives `s_r_valid`/`s_wr_complete` high for exactly cycle N+1.
  - `s_r_data` is the captured `m_r_data`.
  - `s_r_data` holds its value otherwise.
- Full: `cnt == MAX_OUTST` forces `s_ready` = 0. A pop in cycle N restores `s_ready` in cycle N+1.
- Reset mid-operation: in-flight state is discarded and no responses are emitted after reset.

## Configuration
- `CSB_TIMEOUT_EN` defined:
  - A timer counts cycles while the FIFO is non-empty and restarts at 0 on every pop.
  - When the timer reaches `TIMEOUT_CYCLES` with no matched response that cycle, the tracker synthesises the head's response:
    - read: `s_r_valid` = 1 with `s_r_data` = 0xDEAD_BEEF;
    - write: `s_wr_complete` = 1.
  - The synthesised response follows the same one-cycle timing, pops the FIFO and sets `err_o`.
  - A real matched response in the same cycle wins, and the timer restarts.
  - A later real response for the timed-out request is treated as unexpected (dropped, error).
- `CSB_TIMEOUT_EN` undefined: no timer logic, and `TIMEOUT_CYCLES` is ignored.

## Test plan
- Read at 0x0010, `m_ready` = 1, then `m_r_valid` with 0x1234_5678 three cycles later -> `m_valid` one cycle after accept; `s_r_valid` = 1 with 0x1234_5678 one cycle after `m_r_valid`; `outstanding_o` 1 -> 0.
- Five back-to-back reads with `MAX_OUTST` = 4 and no responses -> 4 accepted, `s_ready` = 0, `outstanding_o` = 4; one response -> `s_ready` = 1 next cycle, fifth accepted.
- Posted write (`s_write` = 1, `s_nposted` = 0) at 0x0100 -> forwarded; `outstanding_o` stays 0; no response expected.
- Non-posted write, then `m_r_valid` instead of `m_wr_complete` -> nothing forwarded, `err_o` = 1; a later `m_wr_complete` -> `s_wr_complete` pulse, count 0.
- `m_ready` = 0 for 3 cycles with a request held -> `m_*` stable, `s_ready` = 0; `rst_n` low mid-hold -> all outputs 0 immediately.
- With `CSB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, read never answered -> `s_r_valid` = 1 with 0xDEAD_BEEF, `err_o` = 1, `outstanding_o` = 0.
